// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//   regfile_state_e : clear-sequencer state (ST_CLEAR sweeps, ST_RUN is usable)
//   REG_*           : ABI register index constants
//   slice_lo()      : low bit of slice k in a packed vector of width-w fields
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } regfile_state_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 1;
    localparam int unsigned REG_SP   = 2;
    localparam int unsigned REG_GP   = 3;
    localparam int unsigned REG_TP   = 4;
    localparam int unsigned REG_T0   = 5;
    localparam int unsigned REG_T1   = 6;
    localparam int unsigned REG_T2   = 7;
    localparam int unsigned REG_S0   = 8;
    localparam int unsigned REG_S1   = 9;
    localparam int unsigned REG_A0   = 10;
    localparam int unsigned REG_A1   = 11;
    localparam int unsigned REG_A2   = 12;
    localparam int unsigned REG_A3   = 13;
    localparam int unsigned REG_A4   = 14;
    localparam int unsigned REG_A5   = 15;
    localparam int unsigned REG_A6   = 16;
    localparam int unsigned REG_A7   = 17;
    localparam int unsigned REG_S2   = 18;
    localparam int unsigned REG_S3   = 19;
    localparam int unsigned REG_S4   = 20;
    localparam int unsigned REG_S5   = 21;
    localparam int unsigned REG_S6   = 22;
    localparam int unsigned REG_S7   = 23;
    localparam int unsigned REG_S8   = 24;
    localparam int unsigned REG_S9   = 25;
    localparam int unsigned REG_S10  = 26;
    localparam int unsigned REG_S11  = 27;
    localparam int unsigned REG_T3   = 28;
    localparam int unsigned REG_T4   = 29;
    localparam int unsigned REG_T5   = 30;
    localparam int unsigned REG_T6   = 31;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: CLEAR/RUN sequencer for the register file.
//   clock, reset : system clock, synchronous active-high reset
//   clear_req    : single-cycle request to re-zero the file (honoured only in RUN)
//   clr_en       : high while sweeping; storage zeroes entry clr_idx on each edge
//   clr_idx      : entry being cleared this cycle
//   run          : state is RUN (writes and reads enabled)
//   ready        : registered "file usable" flag
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned SEL_BITS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_req,
    output logic                clr_en,
    output logic [SEL_BITS-1:0] clr_idx,
    output logic                run,
    output logic                ready
);

    regfile_state_e      state_q, state_d;
    logic [SEL_BITS-1:0] clear_cnt_q, clear_cnt_d;
    logic                ready_q, ready_d;

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        ready_d     = ready_q;
        if (reset) begin
            state_d     = ST_CLEAR;
            clear_cnt_d = '0;
            ready_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                    // Last entry is zeroed on the same edge that enters RUN.
                    if (clear_cnt_q == {SEL_BITS{1'b1}}) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_d     = ST_CLEAR;
                        clear_cnt_d = '0;
                        ready_d     = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = '0;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state_q     <= state_d;
        clear_cnt_q <= clear_cnt_d;
        ready_q     <= ready_d;
    end

    assign clr_en  = (state_q == ST_CLEAR);
    assign clr_idx = clear_cnt_q;
    assign run     = (state_q == ST_RUN);
    assign ready   = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with hardware clear sweep.
//   clock, reset : system clock, synchronous active-high reset
//   read_sel     : NUM_RD packed read indices;  read_data : NUM_RD packed combinational data
//   wEn          : per-port write enable; write_sel / write_data : NUM_WR packed index / data
//   int_write    : load int_target from write port 0 data (low ADDRESS_BITS, zero-extended)
//   clear_req    : request a re-zeroing sweep; ready : high when in RUN
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SEL_BITS     = 5,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned NUM_RD       = 2,
    parameter int unsigned NUM_WR       = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_RD*SEL_BITS-1:0]     read_sel,
    output logic [NUM_RD*DATA_WIDTH-1:0]   read_data,
    input  logic [NUM_WR-1:0]              wEn,
    input  logic [NUM_WR*SEL_BITS-1:0]     write_sel,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   write_data,
    input  logic                           int_write,
    output logic [ADDRESS_BITS-1:0]        int_target,
    input  logic                           clear_req,
    output logic                           ready
);

    localparam int unsigned DEPTH = 1 << SEL_BITS;

    logic                  clr_en;
    logic [SEL_BITS-1:0]   clr_idx;
    logic                  run;

    regfile_clear_seq #(
        .SEL_BITS (SEL_BITS)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .run       (run),
        .ready     (ready)
    );

    // Storage has no reset; the sweep is the only initialisation.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_idx] = '0;
        end else if (run && !reset) begin
            // Ascending loop: the highest-numbered port wins on an index collision.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wEn[w] && (write_sel[slice_lo(w, SEL_BITS) +: SEL_BITS] != '0)) begin
                    mem_d[write_sel[slice_lo(w, SEL_BITS) +: SEL_BITS]] =
                        write_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    logic [ADDRESS_BITS-1:0] int_target_q, int_target_d;

    always_comb begin
        int_target_d = int_target_q;
        if (reset) begin
            int_target_d = '0;
        end else if (run && int_write) begin
            // Size cast truncates or zero-extends as ADDRESS_BITS requires.
            int_target_d = ADDRESS_BITS'(write_data[DATA_WIDTH-1:0]);
        end
    end

    always_ff @(posedge clock) begin
        int_target_q <= int_target_d;
    end

    assign int_target = int_target_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [SEL_BITS-1:0]   rsel;
        logic [DATA_WIDTH-1:0] rdata;

        assign rsel = read_sel[k*SEL_BITS +: SEL_BITS];

        always_comb begin
            rdata = mem_q[rsel];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wEn[w] && (write_sel[slice_lo(w, SEL_BITS) +: SEL_BITS] == rsel)) begin
                    rdata = write_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
`endif
            if (!run || (rsel == '0)) begin
                rdata = '0;
            end
        end

        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end

endmodule
